// File: rtl/led_counter_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_counter_ctrl_if: button inputs and counter control strobes (rev 1.0)
// ---------------------------------------------------------------------------
interface led_counter_ctrl_if;
  logic       btn_run;
  logic       btn_step;
  logic       btn_dir;
  logic       btn_clr;
  logic       cnt_en;
  logic       cnt_up;
  logic       cnt_clr;
  logic [1:0] state;

  modport master (
    output btn_run, btn_step, btn_dir, btn_clr,
    input  cnt_en, cnt_up, cnt_clr, state
  );

  modport slave (
    input  btn_run, btn_step, btn_dir, btn_clr,
    output cnt_en, cnt_up, cnt_clr, state
  );
endinterface
`default_nettype wire

// File: rtl/led_counter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_counter_ctrl: push-button run/pause/step/dir/clear sequencer (rev 1.0)
// Optional per-button debouncer compiled in by defining LED_CTRL_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
module led_counter_ctrl #(
  parameter int unsigned TICK_DIV        = 1_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
  input  logic              clk,
  input  logic              reset_n,
  led_counter_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_STEP  = 2'b11;

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] c_LAST   = PW'(TICK_DIV - 1);
  // An out-of-range configuration leaves the controller inert instead of misbehaving.
  localparam logic          c_CFG_OK = (TICK_DIV >= 2) && (DEBOUNCE_CYCLES >= 2);

  // Button vector order: {clr, dir, step, run}.
  logic [3:0] btn_raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] level;
  logic [3:0] prev_q;
  logic [3:0] ev;
  logic       ev_run;
  logic       ev_step;
  logic       ev_dir;
  logic       ev_clr;

  assign btn_raw = {bus.btn_clr, bus.btn_dir, bus.btn_step, bus.btn_run};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef LED_CTRL_DEBOUNCE_EN
  localparam int unsigned   DW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] c_DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  for (genvar g = 0; g < 4; g++) begin : g_debounce
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic          lvl_q;
    logic          lvl_d;

    // Any sample matching the current level restarts the run of differing samples.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync2_q[g] != lvl_q) begin
        if (cnt_q == c_DB_LAST) begin
          lvl_d = sync2_q[g];
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign level[g] = lvl_q;
  end
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= level;
    end
  end

  assign ev      = level & ~prev_q & {4{c_CFG_OK}};
  assign ev_run  = ev[0];
  assign ev_step = ev[1];
  assign ev_dir  = ev[2];
  assign ev_clr  = ev[3];

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick;
  logic          cnt_en_q;
  logic          cnt_en_d;
  logic          cnt_up_q;
  logic          cnt_up_d;
  logic          cnt_clr_q;

  always_comb begin
    state_d = state_q;
    if (ev_clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (ev_run) begin
            state_d = S_RUN;
          end else if (ev_step) begin
            state_d = S_STEP;
          end
        end
        S_RUN: begin
          if (ev_run) begin
            state_d = S_PAUSE;
          end
        end
        default: state_d = S_PAUSE;
      endcase
    end
  end

  // The prescaler advances on every edge that closes a RUN cycle, so ticks
  // land after exactly TICK_DIV cumulative RUN cycles across pauses.
  assign tick = (state_q == S_RUN) && (presc_q == c_LAST);

  always_comb begin
    presc_d = presc_q;
    if (ev_clr) begin
      presc_d = '0;
    end else if (state_q == S_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    cnt_en_d = !ev_clr && (tick || (state_d == S_STEP));
    cnt_up_d = cnt_up_q;
    if (ev_clr) begin
      cnt_up_d = 1'b1;
    end else if (ev_dir) begin
      cnt_up_d = ~cnt_up_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      cnt_en_q  <= 1'b0;
      cnt_up_q  <= 1'b1;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_en_q  <= cnt_en_d;
      cnt_up_q  <= cnt_up_d;
      cnt_clr_q <= ev_clr;
    end
  end

  assign bus.state   = state_q;
  assign bus.cnt_en  = cnt_en_q;
  assign bus.cnt_up  = cnt_up_q;
  assign bus.cnt_clr = cnt_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_led_counter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_led_counter_ctrl: directed and random checks against a behavioural model (rev 1.0)
// ---------------------------------------------------------------------------
module tb_led_counter_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_STEP  = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  led_counter_ctrl_if bus ();

  led_counter_ctrl #(
    .TICK_DIV        (TD),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_en     = 0;

  // Reference model: sample history per button, run-cycle tally, mode.
  logic [3:0] sh [0:15];
  logic [3:0] lv_last;
  logic [3:0] db_lvl;
  int         m_state;
  int         m_runs;
  logic       m_up;
  logic       m_en;
  logic       m_clr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] b, input logic rn);
    logic [3:0] lv;
    logic [3:0] ev;
    logic       fire;
    if (!rn) begin
      for (int j = 0; j < 16; j++) sh[j] = '0;
      lv_last = '0;
      db_lvl  = '0;
      m_state = M_IDLE;
      m_runs  = 0;
      m_up    = 1'b1;
      m_en    = 1'b0;
      m_clr   = 1'b0;
      return;
    end
`ifdef LED_CTRL_DEBOUNCE_EN
    lv = db_lvl;
    for (int i = 0; i < 4; i++) begin
      logic flip;
      flip = 1'b1;
      for (int j = 1; j <= DB; j++) if (sh[j][i] == db_lvl[i]) flip = 1'b0;
      if (flip) db_lvl[i] = ~db_lvl[i];
    end
`else
    lv = sh[1];
`endif
    ev      = lv & ~lv_last;
    lv_last = lv;
    for (int j = 15; j > 0; j--) sh[j] = sh[j-1];
    sh[0] = b;

    fire = 1'b0;
    if (m_state == M_RUN) begin
      m_runs++;
      if (m_runs == TD) begin
        m_runs = 0;
        fire   = 1'b1;
      end
    end
    m_clr = ev[3];
    m_en  = 1'b0;
    if (ev[3]) begin
      m_state = M_IDLE;
      m_runs  = 0;
      m_up    = 1'b1;
    end else begin
      if (ev[2]) m_up = ~m_up;
      case (m_state)
        M_IDLE, M_PAUSE: begin
          if (ev[0]) m_state = M_RUN;
          else if (ev[1]) m_state = M_STEP;
        end
        M_RUN:   if (ev[0]) m_state = M_PAUSE;
        default: m_state = M_PAUSE;
      endcase
      m_en = fire || (m_state == M_STEP);
    end
  endtask

  // b = {clr, dir, step, run}
  task automatic cyc(input logic [3:0] b, input logic rn);
    {bus.btn_clr, bus.btn_dir, bus.btn_step, bus.btn_run} = b;
    reset_n = rn;
    @(posedge clk);
    model_edge(b, rn);
    @(negedge clk);
    chk("state",   32'(bus.state),   32'(m_state));
    chk("cnt_en",  32'(bus.cnt_en),  32'(m_en));
    chk("cnt_up",  32'(bus.cnt_up),  32'(m_up));
    chk("cnt_clr", 32'(bus.cnt_clr), 32'(m_clr));
    chk("en_clr_excl", 32'(bus.cnt_en & bus.cnt_clr), 32'd0);
    if (bus.cnt_en === 1'b1) n_en++;
  endtask

  initial begin
    logic [3:0] b;
    b = '0;
    reset_n = 1'b0;
    {bus.btn_clr, bus.btn_dir, bus.btn_step, bus.btn_run} = 4'b0000;
    repeat (3) cyc(4'b0000, 1'b0);
    chk("rst_state",   32'(bus.state),   32'd0);
    chk("rst_cnt_en",  32'(bus.cnt_en),  32'd0);
    chk("rst_cnt_up",  32'(bus.cnt_up),  32'd1);
    chk("rst_cnt_clr", 32'(bus.cnt_clr), 32'd0);

`ifdef LED_CTRL_DEBOUNCE_EN
    cyc(4'b0000, 1'b1);
    cyc(4'b0001, 1'b1);
    cyc(4'b0001, 1'b1);
    repeat (10) cyc(4'b0000, 1'b1);
    chk("db_glitch_ignored", 32'(bus.state), 32'd0);
    repeat (3) cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("db_not_yet_run", 32'(bus.state), 32'd0);
    cyc(4'b0000, 1'b1);
    chk("db_run_entry", 32'(bus.state), 32'd1);
    repeat (10) cyc(4'b0000, 1'b1);
`else
    // Run entry and first tick
    cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("s1_run_entry", 32'(bus.state), 32'd1);
    repeat (3) cyc(4'b0000, 1'b1);
    chk("s1_no_early_tick", 32'(bus.cnt_en), 32'd0);
    cyc(4'b0000, 1'b1);
    chk("s1_first_tick", 32'(bus.cnt_en), 32'd1);
    chk("s1_up", 32'(bus.cnt_up), 32'd1);
    n_en = 0;
    repeat (7) cyc(4'b0000, 1'b1);
    cyc(4'b0001, 1'b1);
    chk("s1_period", 32'(n_en), 32'd2);
    // Pause with two RUN cycles already counted, then resume
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("s2_paused", 32'(bus.state), 32'd2);
    n_en = 0;
    repeat (20) cyc(4'b0000, 1'b1);
    chk("s2_pause_silent", 32'(n_en), 32'd0);
    cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("s2_resumed", 32'(bus.state), 32'd1);
    cyc(4'b0000, 1'b1);
    chk("s2_no_tick_yet", 32'(bus.cnt_en), 32'd0);
    cyc(4'b0000, 1'b1);
    chk("s2_resume_tick", 32'(bus.cnt_en), 32'd1);
    cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("s3_paused", 32'(bus.state), 32'd2);
    // Single steps from PAUSE
    n_en = 0;
    repeat (3) begin
      cyc(4'b0010, 1'b1);
      cyc(4'b0000, 1'b1);
      chk("s3_pre_step", 32'(bus.state), 32'd2);
      cyc(4'b0000, 1'b1);
      chk("s3_step_state", 32'(bus.state), 32'd3);
      chk("s3_step_en", 32'(bus.cnt_en), 32'd1);
      cyc(4'b0000, 1'b1);
      chk("s3_back_pause", 32'(bus.state), 32'd2);
      cyc(4'b0000, 1'b1);
    end
    chk("s3_three_pulses", 32'(n_en), 32'd3);
    n_en = 0;
    repeat (50) cyc(4'b0010, 1'b1);
    repeat (4) cyc(4'b0000, 1'b1);
    chk("s3_held_one_pulse", 32'(n_en), 32'd1);
    // Direction toggle, then dir+clr together in RUN
    cyc(4'b0100, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("s4_dir_down", 32'(bus.cnt_up), 32'd0);
    cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("s4_run", 32'(bus.state), 32'd1);
    cyc(4'b1100, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("s4_clr_pulse", 32'(bus.cnt_clr), 32'd1);
    chk("s4_idle", 32'(bus.state), 32'd0);
    chk("s4_up_forced", 32'(bus.cnt_up), 32'd1);
    n_en = 0;
    repeat (10) cyc(4'b0000, 1'b1);
    chk("s4_quiet", 32'(n_en), 32'd0);
    // run+step together from IDLE, then reset on the tick edge
    cyc(4'b0011, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("s5_run_wins", 32'(bus.state), 32'd1);
    cyc(4'b0000, 1'b1);
    chk("s5_no_step", 32'(bus.cnt_en), 32'd0);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b0);
    chk("s5_rst_en", 32'(bus.cnt_en), 32'd0);
    chk("s5_rst_state", 32'(bus.state), 32'd0);
    cyc(4'b0000, 1'b1);
`endif

    // Random button activity with occasional resets
    for (int t = 0; t < 2500; t++) begin
      if ($urandom_range(0, 299) == 0) begin
        b = '0;
        repeat (2) cyc(b, 1'b0);
      end
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
      if ($urandom_range(0, 59) == 0) b[3] = ~b[3];
      else if (b[3] && $urandom_range(0, 3) == 0) b[3] = 1'b0;
      cyc(b, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
